// File: rtl/mips_mem_responder.sv
// mips_mem_responder
//   Memory-side responder for the 64-bit multicycle CPU bus. It serves byte,
//   word and doubleword accesses from a 32-bit-wide synchronous RAM.
//   A doubleword access takes two RAM cycles, and ready drops for the second one.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   dataadr    byte address; only bits [AW+1:0] are decoded
//   writedata  store data
//   memwrite   00 read, 01 byte store, 10 word store, 11 doubleword store
//   dword      on reads: 1 = 64-bit read, 0 = 32-bit read
//   readdata   registered read result
//   ready      1 when a new access is accepted this cycle
//   err        sticky misaligned-access flag, cleared only by reset
//
// State table
//   state | meaning
//   IDLE  | decode bus every cycle, ready = 1
//   RD_HI | second half of a dword read: fetch mem[idx_cap+1] into readdata[63:32]
//   WR_HI | second half of a dword store: write captured high word to mem[idx_cap+1]

module mips_mem_responder #(
   parameter int N  = 64,
   parameter int AW = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] dataadr,
   input  logic [N-1:0] writedata,
   input  logic [1:0]   memwrite,
   input  logic         dword,
   output logic [N-1:0] readdata,
   output logic         ready,
   output logic         err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_HI = 2'd1,
      WR_HI = 2'd2
   } state_t;

   state_t state, next_state;

   logic [31:0]   mem [0:(1<<AW)-1];

   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic [AW-1:0] idx_cap;
   logic [AW-1:0] idx_hi;
   logic [31:0]   hi_cap;

   logic          mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_widx;
   logic [31:0]   mem_wdata;
   logic          rd_word;
   logic          rd_dlo;
   logic          rd_dhi;
   logic [AW-1:0] rd_idx;
   logic          cap;
   logic          set_err;

   logic          unused_addr;
   assign unused_addr = ^dataadr[N-1:AW+2];

   assign idx    = dataadr[AW+1:2];
   assign lane   = dataadr[1:0];
   // Aligned dwords always have an even idx, so +1 cannot run off the end.
   assign idx_hi = idx_cap + {{(AW-1){1'b0}}, 1'b1};
   assign ready  = (state == IDLE);

   always_comb begin
      next_state = state;
      mem_we     = 1'b0;
      mem_be     = 4'b0000;
      mem_widx   = idx;
      mem_wdata  = writedata[31:0];
      rd_word    = 1'b0;
      rd_dlo     = 1'b0;
      rd_dhi     = 1'b0;
      rd_idx     = idx;
      cap        = 1'b0;
      set_err    = 1'b0;
      case (state)
         IDLE: begin
            case (memwrite)
               2'b00: begin
                  if (dword) begin
                     if (dataadr[2:0] == 3'b000) begin
                        rd_dlo     = 1'b1;
                        cap        = 1'b1;
                        next_state = RD_HI;
                     end else begin
                        set_err = 1'b1;
                     end
                  end else if (lane == 2'b00) begin
                     rd_word = 1'b1;
                  end else begin
                     set_err = 1'b1;
                  end
               end
               2'b01: begin
                  // Replicate the byte on all lanes; the byte enable picks the target.
                  mem_we    = 1'b1;
                  mem_be    = 4'b0001 << lane;
                  mem_wdata = {4{writedata[7:0]}};
               end
               2'b10: begin
                  if (lane == 2'b00) begin
                     mem_we = 1'b1;
                     mem_be = 4'b1111;
                  end else begin
                     set_err = 1'b1;
                  end
               end
               default: begin
                  if (dataadr[2:0] == 3'b000) begin
                     mem_we     = 1'b1;
                     mem_be     = 4'b1111;
                     cap        = 1'b1;
                     next_state = WR_HI;
                  end else begin
                     set_err = 1'b1;
                  end
               end
            endcase
         end
         RD_HI: begin
            rd_dhi     = 1'b1;
            rd_idx     = idx_hi;
            next_state = IDLE;
         end
         WR_HI: begin
            mem_we     = 1'b1;
            mem_be     = 4'b1111;
            mem_widx   = idx_hi;
            mem_wdata  = hi_cap;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         readdata <= '0;
         err      <= 1'b0;
         idx_cap  <= '0;
         hi_cap   <= '0;
      end else begin
         state <= next_state;
         if (rd_word) readdata <= {32'b0, mem[rd_idx]};
         if (rd_dlo)  readdata[31:0]  <= mem[rd_idx];
         if (rd_dhi)  readdata[63:32] <= mem[rd_idx];
         if (set_err) err <= 1'b1;
         if (cap) begin
            idx_cap <= idx;
            hi_cap  <= writedata[63:32];
         end
      end
   end

   // RAM is not reset; a reset held across an edge suppresses any pending write
   // so an interrupted dword store never writes its high word.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_mips_mem_responder.sv
module tb_mips_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] dataadr = '0;
   logic [63:0] writedata = '0;
   logic [1:0]  memwrite = 2'b00;
   logic        dword = 1'b0;
   logic [63:0] readdata;
   logic        ready;
   logic        err;

   int n_assert = 0;
   int n_fail   = 0;

   logic [63:0] exp_q [$];

   mips_mem_responder #(.N(64), .AW(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .dataadr   (dataadr),
      .writedata (writedata),
      .memwrite  (memwrite),
      .dword     (dword),
      .readdata  (readdata),
      .ready     (ready),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      logic [63:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         check(tag, readdata, e);
      end
   endtask

   task automatic word_store(input logic [63:0] a, input logic [31:0] d);
      dataadr   = a;
      writedata = {32'h0, d};
      memwrite  = 2'b10;
      dword     = 1'b0;
      cycle();
      memwrite  = 2'b00;
   endtask

   task automatic byte_store(input logic [63:0] a, input logic [7:0] d);
      dataadr   = a;
      writedata = {56'hFFFF_FFFF_FFFF_FF, d};
      memwrite  = 2'b01;
      dword     = 1'b0;
      cycle();
      memwrite  = 2'b00;
   endtask

   task automatic word_read(input string tag, input logic [63:0] a, input logic [31:0] e);
      dataadr  = a;
      memwrite = 2'b00;
      dword    = 1'b0;
      exp_q.push_back({32'h0, e});
      cycle();
      pop_check(tag);
   endtask

   initial begin
      // reset
      #1 reset = 1'b1;
      cycle();
      cycle();
      check("rst_readdata", readdata, 64'h0);
      check("rst_ready", {63'h0, ready}, 64'h1);
      check("rst_err", {63'h0, err}, 64'h0);
      reset = 1'b0;

      word_store(64'h60, 32'h0000_0000);
      word_store(64'h64, 32'hCAFE_F00D);
      word_store(64'h44, 32'h4444_4444);
      word_store(64'h48, 32'h4848_4848);
      word_store(64'h58, 32'h5858_5858);

      // word store / read
      word_store(64'h10, 32'hDEAD_BEEF);
      check("wst_ready", {63'h0, ready}, 64'h1);
      word_read("wrd_10", 64'h10, 32'hDEAD_BEEF);
      check("wrd_ready", {63'h0, ready}, 64'h1);
      check("wrd_err", {63'h0, err}, 64'h0);

      // dword store then dword read
      dataadr   = 64'h20;
      writedata = 64'h0123_4567_89AB_CDEF;
      memwrite  = 2'b11;
      cycle();
      check("dst_ready_lo", {63'h0, ready}, 64'h0);
      memwrite  = 2'b00;
      cycle();
      check("dst_ready_back", {63'h0, ready}, 64'h1);
      dataadr  = 64'h20;
      dword    = 1'b1;
      exp_q.push_back(64'h0123_4567_89AB_CDEF);
      cycle();
      check("drd_ready_lo", {63'h0, ready}, 64'h0);
      check("drd_half", readdata, 64'h0000_0000_89AB_CDEF);
      dword = 1'b0;
      cycle();
      check("drd_ready_back", {63'h0, ready}, 64'h1);
      pop_check("drd_full");
      word_read("wrd_20", 64'h20, 32'h89AB_CDEF);
      word_read("wrd_24", 64'h24, 32'h0123_4567);

      // byte stores
      word_store(64'h30, 32'h1122_3344);
      byte_store(64'h30, 8'hAA);
      byte_store(64'h33, 8'h55);
      word_read("byte_merge", 64'h30, 32'h5522_33AA);

      // misaligned accesses
      word_read("pre_mis", 64'h24, 32'h0123_4567);
      dataadr = 64'h42;
      cycle();
      check("mis_rd_err", {63'h0, err}, 64'h1);
      check("mis_rd_data", readdata, 64'h0000_0000_0123_4567);
      dataadr   = 64'h44;
      writedata = 64'hFFFF_FFFF_FFFF_FFFF;
      memwrite  = 2'b11;
      cycle();
      check("mis_dst_ready", {63'h0, ready}, 64'h1);
      check("mis_dst_data", readdata, 64'h0000_0000_0123_4567);
      memwrite  = 2'b00;
      word_read("mis_mem_44", 64'h44, 32'h4444_4444);
      word_read("mis_mem_48", 64'h48, 32'h4848_4848);
      check("err_sticky", {63'h0, err}, 64'h1);

      // inputs ignored during WR_HI
      dataadr   = 64'h50;
      writedata = 64'hA5A5_A5A5_5A5A_5A5A;
      memwrite  = 2'b11;
      cycle();
      dataadr   = 64'h58;
      writedata = 64'hFFFF_FFFF_FFFF_FFFF;
      memwrite  = 2'b10;
      cycle();
      memwrite  = 2'b00;
      check("wrhi_ready", {63'h0, ready}, 64'h1);
      word_read("wrhi_50", 64'h50, 32'h5A5A_5A5A);
      word_read("wrhi_54", 64'h54, 32'hA5A5_A5A5);
      word_read("wrhi_58", 64'h58, 32'h5858_5858);

      // reset during WR_HI
      dataadr   = 64'h60;
      writedata = 64'hFFFF_FFFF_0000_0000;
      memwrite  = 2'b11;
      cycle();
      check("rhi_in_wrhi", {63'h0, ready}, 64'h0);
      memwrite  = 2'b00;
      #2 reset = 1'b1;
      #1;
      check("rhi_rst_data", readdata, 64'h0);
      check("rhi_rst_ready", {63'h0, ready}, 64'h1);
      cycle();
      reset = 1'b0;
      check("rhi_err_clr", {63'h0, err}, 64'h0);
      word_read("rhi_60", 64'h60, 32'h0000_0000);
      word_read("rhi_64", 64'h64, 32'hCAFE_F00D);

      check("sb_drained", 64'(exp_q.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
Memory-side responder for the 64-bit multicycle CPU's data/instruction bus (dataadr, writedata, memwrite, dword, readdata). It serves byte, word and doubleword accesses from a 32-bit-wide synchronous RAM. Doubleword accesses are split into two RAM cycles by a small FSM. A ready output is provided so the CPU controller can stall during the second phase.

Parameters:
N, 64, bus data/address width (fixed at 64; other values unsupported)
AW, 8, RAM word-index bits; depth = 2^AW 32-bit words

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
dataadr  input  N  byte address from CPU; only bits [AW+1:0] used, upper bits ignored
writedata  input  N  store data from CPU
memwrite  input  2  00 none, 01 byte store, 10 word store, 11 doubleword store
dword  input  1  on reads (memwrite=00): 1 = 64-bit read, 0 = 32-bit read
readdata  output  N  registered read result
ready  output  1  1 = responder accepts a new access this cycle
err  output  1  sticky misaligned-access flag

Behaviour:
- idx = dataadr[AW+1:2]; lane = dataadr[1:0].
- States: IDLE, RD_HI, WR_HI. ready = (state==IDLE).
- Reset (async): state IDLE, readdata 0, ready 1, err 0. RAM contents not reset and not altered by reset.
- In IDLE an access is decoded every cycle; there is no request strobe. memwrite=00 is a read.
- Word read (memwrite=00, dword=0):
  - requires lane==0;
  - next edge: readdata <= {32'b0, mem[idx]}; stays IDLE.
  - Latency 1 cycle; back-to-back reads allowed every cycle.
- Dword read (memwrite=00, dword=1):
  - requires dataadr[2:0]==0;
  - edge 1: readdata[31:0] <= mem[idx], capture idx, go RD_HI (ready=0);
  - edge 2: readdata[63:32] <= mem[idx_cap+1], go IDLE.
  - Full result valid the cycle after ready returns to 1. readdata[63:32] holds its old value during RD_HI.
- Byte store (01): mem[idx] byte lane `lane` <= writedata[7:0]; other bytes unchanged; any lane allowed.
- Word store (10): requires lane==0; mem[idx] <= writedata[31:0].
- Dword store (11):
  - requires dataadr[2:0]==0;
  - edge 1: mem[idx] <= writedata[31:0], capture idx and writedata[63:32], go WR_HI;
  - edge 2: mem[idx_cap+1] <= captured high word, go IDLE.
- dword is ignored on stores; memwrite alone selects store width.
- readdata is unchanged on store cycles and in WR_HI.
- While ready=0, all bus inputs are ignored; the second phase uses only captured values.
- Misaligned access (word with lane!=0; dword read/store with dataadr[2:0]!=0):
  - no RAM write, readdata unchanged, stays IDLE;
  - err <= 1, cleared only by reset.
- Wrap: aligned dword always has even idx, so idx_cap+1 never exceeds depth-1; no wrap logic required.
- Read-after-write: a read of an address in the cycle after its store completes returns the new data. Store and read cannot coincide because there is a single port.
- Reset during RD_HI or WR_HI:
  - FSM returns to IDLE;
  - an interrupted dword store leaves the low word written and the high word unwritten;
  - readdata clears to 0.

Test Plan:
- Reset, then word store 0xDEADBEEF at 0x10, then word read 0x10 -> one cycle later readdata=0x00000000DEADBEEF, ready stays 1, err=0.
- Dword store 0x0123456789ABCDEF at 0x20 -> ready=0 for exactly one cycle; dword read 0x20 -> ready low one cycle, then readdata=0x0123456789ABCDEF; word reads 0x20/0x24 return 0x89ABCDEF / 0x01234567.
- Word 0x11223344 at 0x30, then byte stores 0xAA lane 0 and 0x55 lane 3 -> word read 0x30 = 0x55223AA? No: expected 0x552233AA.
- Word read at 0x42, then dword store at 0x44 -> err=1, memory and readdata unchanged, err stays 1 across later good accesses until reset.
- Dword store at 0x50; change dataadr/writedata/memwrite during WR_HI -> only the captured high word is written to 0x54, and the new inputs are not acted on.
- Assert reset during WR_HI of dword store 0xFFFFFFFF00000000 to 0x60 over a prior 0 -> readdata=0, ready=1; word read 0x60=0x00000000 and 0x64 retains its old value.
